// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared constants for the ALU reservation station.
//   - Opcode width and encodings (NOP = 0 means "no micro-op").
//   - Default depth and ROB tag width for alu_rs.
package alu_rs_pkg;

  localparam int unsigned OpW = 7;
  typedef logic [OpW-1:0] op_t;

  localparam op_t OpNop = 7'd0;
  localparam op_t OpAdd = 7'd1;
  localparam op_t OpSub = 7'd2;
  localparam op_t OpAnd = 7'd3;
  localparam op_t OpOr  = 7'd4;
  localparam op_t OpXor = 7'd5;
  localparam op_t OpBeq = 7'd16;
  localparam op_t OpBne = 7'd17;

  localparam int unsigned RsDepthDef = 8;
  localparam int unsigned TagWDef    = 5;

endpackage

// File: rtl/alu_rs_pick.sv
// rs_pick: lowest-index priority encoder.
//   req_i   : request vector, bit 0 has highest priority
//   idx_o   : index of the lowest set bit (0 when none set)
//   found_o : at least one bit of req_i is set
module rs_pick #(
  parameter int unsigned N    = 8,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  output logic [IdxW-1:0] idx_o,
  output logic            found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && !found_o) begin
        idx_o   = IdxW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the integer ALU.
// Buffers dispatched micro-ops, wakes pending operands from the CDB and issues at most one
// ready micro-op per cycle through registered ALU operand outputs.
//   clk_in, rst_in (async, active-low), rdy_in (global stall when low), flush_in
//   dis_*  : dispatch interface (op, operand values/tags/pending flags, imm, pc, rob tag)
//   cdb_*  : common data bus broadcast (valid, tag, value)
//   full   : every entry busy
//   alu_*  : issued micro-op; alu_op = 0 means no issue this cycle
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned DEPTH = RsDepthDef,
  parameter int unsigned TAG_W = TagWDef
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             dis_valid,
  input  logic [OpW-1:0]   dis_op,
  input  logic [31:0]      dis_vi,
  input  logic [31:0]      dis_vj,
  input  logic [TAG_W-1:0] dis_qi,
  input  logic [TAG_W-1:0] dis_qj,
  input  logic             dis_qi_v,
  input  logic             dis_qj_v,
  input  logic [31:0]      dis_imm,
  input  logic [31:0]      dis_pc,
  input  logic [TAG_W-1:0] dis_rob,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic             full,
  output logic [OpW-1:0]   alu_op,
  output logic [31:0]      alu_vi,
  output logic [31:0]      alu_vj,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [TAG_W-1:0] alu_rd
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] busy_q, busy_d, qiv_q, qiv_d, qjv_q, qjv_d;
  op_t              op_q  [DEPTH];
  op_t              op_d  [DEPTH];
  logic [31:0]      vi_q  [DEPTH];
  logic [31:0]      vi_d  [DEPTH];
  logic [31:0]      vj_q  [DEPTH];
  logic [31:0]      vj_d  [DEPTH];
  logic [31:0]      imm_q [DEPTH];
  logic [31:0]      imm_d [DEPTH];
  logic [31:0]      pc_q  [DEPTH];
  logic [31:0]      pc_d  [DEPTH];
  logic [TAG_W-1:0] qi_q  [DEPTH];
  logic [TAG_W-1:0] qi_d  [DEPTH];
  logic [TAG_W-1:0] qj_q  [DEPTH];
  logic [TAG_W-1:0] qj_d  [DEPTH];
  logic [TAG_W-1:0] rob_q [DEPTH];
  logic [TAG_W-1:0] rob_d [DEPTH];

  op_t              alu_op_q, alu_op_d;
  logic [31:0]      alu_vi_q, alu_vi_d, alu_vj_q, alu_vj_d;
  logic [31:0]      alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;
  logic [TAG_W-1:0] alu_rd_q, alu_rd_d;

  // Ready and free are derived from registered state only, so a slot freed by issue
  // cannot be refilled in the same cycle and a woken entry issues one cycle later.
  logic [DEPTH-1:0] ready, free;
  logic [IdxW-1:0]  free_idx, iss_idx;
  logic             free_found, iss_found;

  assign ready = busy_q & ~qiv_q & ~qjv_q;
  assign free  = ~busy_q;

  rs_pick #(.N(DEPTH), .IdxW(IdxW)) u_pick_free (
    .req_i   (free),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  rs_pick #(.N(DEPTH), .IdxW(IdxW)) u_pick_ready (
    .req_i   (ready),
    .idx_o   (iss_idx),
    .found_o (iss_found)
  );

  always_comb begin
    busy_d    = busy_q;
    qiv_d     = qiv_q;
    qjv_d     = qjv_q;
    op_d      = op_q;
    vi_d      = vi_q;
    vj_d      = vj_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    qi_d      = qi_q;
    qj_d      = qj_q;
    rob_d     = rob_q;
    alu_op_d  = alu_op_q;
    alu_vi_d  = alu_vi_q;
    alu_vj_d  = alu_vj_q;
    alu_imm_d = alu_imm_q;
    alu_pc_d  = alu_pc_q;
    alu_rd_d  = alu_rd_q;

    if (rdy_in) begin
      if (flush_in) begin
        busy_d   = '0;
        alu_op_d = OpNop;
      end else begin
        // CDB wake-up of pending operands in busy entries.
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (cdb_valid && busy_q[i]) begin
            if (qiv_q[i] && (qi_q[i] == cdb_tag)) begin
              vi_d[i]  = cdb_value;
              qiv_d[i] = 1'b0;
            end
            if (qjv_q[i] && (qj_q[i] == cdb_tag)) begin
              vj_d[i]  = cdb_value;
              qjv_d[i] = 1'b0;
            end
          end
        end

        if (iss_found) begin
          busy_d[iss_idx] = 1'b0;
          alu_op_d        = op_q[iss_idx];
          alu_vi_d        = vi_q[iss_idx];
          alu_vj_d        = vj_q[iss_idx];
          alu_imm_d       = imm_q[iss_idx];
          alu_pc_d        = pc_q[iss_idx];
          alu_rd_d        = rob_q[iss_idx];
        end else begin
          alu_op_d = OpNop;
        end

        // free_found is false exactly when full, so a dispatch while full is dropped.
        if (dis_valid && free_found && (dis_op != OpNop)) begin
          busy_d[free_idx] = 1'b1;
          op_d[free_idx]   = dis_op;
          imm_d[free_idx]  = dis_imm;
          pc_d[free_idx]   = dis_pc;
          rob_d[free_idx]  = dis_rob;
          qi_d[free_idx]   = dis_qi;
          qj_d[free_idx]   = dis_qj;
          // Bypass: a producer broadcasting in the dispatch cycle would otherwise be missed.
          if (dis_qi_v && cdb_valid && (cdb_tag == dis_qi)) begin
            vi_d[free_idx]  = cdb_value;
            qiv_d[free_idx] = 1'b0;
          end else begin
            vi_d[free_idx]  = dis_vi;
            qiv_d[free_idx] = dis_qi_v;
          end
          if (dis_qj_v && cdb_valid && (cdb_tag == dis_qj)) begin
            vj_d[free_idx]  = cdb_value;
            qjv_d[free_idx] = 1'b0;
          end else begin
            vj_d[free_idx]  = dis_vj;
            qjv_d[free_idx] = dis_qj_v;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q    <= '0;
      qiv_q     <= '0;
      qjv_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_q[i]  <= OpNop;
        vi_q[i]  <= '0;
        vj_q[i]  <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
        qi_q[i]  <= '0;
        qj_q[i]  <= '0;
        rob_q[i] <= '0;
      end
      alu_op_q  <= OpNop;
      alu_vi_q  <= '0;
      alu_vj_q  <= '0;
      alu_imm_q <= '0;
      alu_pc_q  <= '0;
      alu_rd_q  <= '0;
    end else begin
      busy_q    <= busy_d;
      qiv_q     <= qiv_d;
      qjv_q     <= qjv_d;
      op_q      <= op_d;
      vi_q      <= vi_d;
      vj_q      <= vj_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      qi_q      <= qi_d;
      qj_q      <= qj_d;
      rob_q     <= rob_d;
      alu_op_q  <= alu_op_d;
      alu_vi_q  <= alu_vi_d;
      alu_vj_q  <= alu_vj_d;
      alu_imm_q <= alu_imm_d;
      alu_pc_q  <= alu_pc_d;
      alu_rd_q  <= alu_rd_d;
    end
  end

  assign full    = &busy_q;
  assign alu_op  = alu_op_q;
  assign alu_vi  = alu_vi_q;
  assign alu_vj  = alu_vj_q;
  assign alu_imm = alu_imm_q;
  assign alu_pc  = alu_pc_q;
  assign alu_rd  = alu_rd_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed bench for alu_rs with an issue scoreboard.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        dis_valid = 1'b0;
  logic [6:0]  dis_op = '0;
  logic [31:0] dis_vi = '0, dis_vj = '0, dis_imm = '0, dis_pc = '0;
  logic [4:0]  dis_qi = '0, dis_qj = '0, dis_rob = '0;
  logic        dis_qi_v = 1'b0, dis_qj_v = 1'b0;
  logic        cdb_valid = 1'b0;
  logic [4:0]  cdb_tag = '0;
  logic [31:0] cdb_value = '0;
  logic        full;
  logic [6:0]  alu_op;
  logic [31:0] alu_vi, alu_vj, alu_imm, alu_pc;
  logic [4:0]  alu_rd;

  alu_rs #(.DEPTH(8), .TAG_W(5)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush_in  (flush_in),
    .dis_valid (dis_valid),
    .dis_op    (dis_op),
    .dis_vi    (dis_vi),
    .dis_vj    (dis_vj),
    .dis_qi    (dis_qi),
    .dis_qj    (dis_qj),
    .dis_qi_v  (dis_qi_v),
    .dis_qj_v  (dis_qj_v),
    .dis_imm   (dis_imm),
    .dis_pc    (dis_pc),
    .dis_rob   (dis_rob),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .full      (full),
    .alu_op    (alu_op),
    .alu_vi    (alu_vi),
    .alu_vj    (alu_vj),
    .alu_imm   (alu_imm),
    .alu_pc    (alu_pc),
    .alu_rd    (alu_rd)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [6:0]  op;
    logic [31:0] vi, vj, imm, pc;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_iss(input int c, input logic [6:0] op, input logic [31:0] vi,
                            input logic [31:0] vj, input logic [31:0] imm,
                            input logic [31:0] pc, input logic [4:0] rd);
    exp_t e;
    e.cyc = c; e.op = op; e.vi = vi; e.vj = vj; e.imm = imm; e.pc = pc; e.rd = rd;
    exp_q.push_back(e);
  endtask

  // Issue monitor: every non-zero alu_op must match the oldest expectation in its cycle.
  always @(negedge clk_in) begin
    exp_t e;
    if (alu_op !== 7'd0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue_op", {25'd0, alu_op}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("iss_cycle", cyc, e.cyc);
        chk("iss_op", {25'd0, alu_op}, {25'd0, e.op});
        chk("iss_vi", alu_vi, e.vi);
        chk("iss_vj", alu_vj, e.vj);
        chk("iss_imm", alu_imm, e.imm);
        chk("iss_pc", alu_pc, e.pc);
        chk("iss_rd", {27'd0, alu_rd}, {27'd0, e.rd});
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk("missing_issue_pc", 32'd0, e.pc);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    dis_valid = 1'b0;
    cdb_valid = 1'b0;
    flush_in  = 1'b0;
  endtask

  task automatic drive_dis(input logic [6:0] op, input logic [31:0] vi, input logic [31:0] vj,
                           input logic [4:0] qi, input logic qiv, input logic [4:0] qj,
                           input logic qjv, input logic [31:0] imm, input logic [31:0] pc,
                           input logic [4:0] rob);
    dis_valid = 1'b1; dis_op = op; dis_vi = vi; dis_vj = vj;
    dis_qi = qi; dis_qi_v = qiv; dis_qj = qj; dis_qj_v = qjv;
    dis_imm = imm; dis_pc = pc; dis_rob = rob;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
  endtask

  initial begin
    // Reset values.
    tick(); tick();
    chk("rst_alu_op", {25'd0, alu_op}, 32'd0);
    chk("rst_alu_vi", alu_vi, 32'd0);
    chk("rst_alu_vj", alu_vj, 32'd0);
    chk("rst_alu_imm", alu_imm, 32'd0);
    chk("rst_alu_pc", alu_pc, 32'd0);
    chk("rst_alu_rd", {27'd0, alu_rd}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    rst_in = 1'b1;
    tick();

    // Both operands ready: issue one cycle after the dispatch edge, for one cycle.
    drive_dis(OpAdd, 32'd5, 32'd7, 5'd0, 1'b0, 5'd0, 1'b0, 32'h100, 32'h1000, 5'd1);
    expect_iss(cyc + 2, OpAdd, 32'd5, 32'd7, 32'h100, 32'h1000, 5'd1);
    tick(); idle(); tick(); tick(); tick();

    // vj pending on tag 3, woken two cycles later.
    drive_dis(OpSub, 32'd20, 32'hdead, 5'd0, 1'b0, 5'd3, 1'b1, 32'h4, 32'h1004, 5'd2);
    tick(); idle(); tick(); tick();
    cdb(5'd3, 32'h10);
    expect_iss(cyc + 2, OpSub, 32'd20, 32'h10, 32'h4, 32'h1004, 5'd2);
    tick(); idle(); tick(); tick();

    // Dispatch-cycle CDB bypass on vi.
    drive_dis(OpAdd, 32'hbeef, 32'd3, 5'd4, 1'b1, 5'd0, 1'b0, 32'h8, 32'h1008, 5'd3);
    cdb(5'd4, 32'd9);
    expect_iss(cyc + 2, OpAdd, 32'd9, 32'd3, 32'h8, 32'h1008, 5'd3);
    tick(); idle(); tick(); tick();

    // Fill all 8 entries with blocked ops; 9th dispatch is dropped.
    for (int i = 0; i < 8; i++) begin
      drive_dis(OpOr, 32'hbad, 32'(i), 5'(16 + i), 1'b1, 5'd0, 1'b0, 32'(i),
                32'h2000 + 32'(4 * i), 5'(8 + i));
      tick();
      if (i == 6) chk("full_at_7", {31'd0, full}, 32'd0);
    end
    chk("full_at_8", {31'd0, full}, 32'd1);
    drive_dis(OpAnd, 32'd1, 32'd2, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'h3000, 5'd30);
    tick(); idle();
    chk("full_after_drop", {31'd0, full}, 32'd1);
    cdb(5'd16, 32'h77);
    expect_iss(cyc + 2, OpOr, 32'h77, 32'd0, 32'd0, 32'h2000, 5'd8);
    tick(); idle();
    chk("full_woken", {31'd0, full}, 32'd1);
    tick();
    chk("full_after_issue", {31'd0, full}, 32'd0);
    tick();
    flush_in = 1'b1;
    tick(); idle();
    chk("full_after_flush", {31'd0, full}, 32'd0);
    tick();

    // Flush beats a same-cycle dispatch and a same-cycle issue.
    for (int i = 0; i < 3; i++) begin
      drive_dis(OpXor, 32'd1, 32'd2, 5'(20 + i), 1'b1, 5'd0, 1'b0, 32'd0,
                32'h4000 + 32'(4 * i), 5'(i));
      tick();
    end
    drive_dis(OpAdd, 32'd11, 32'd22, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'h5000, 5'd5);
    tick();
    drive_dis(OpSub, 32'd33, 32'd44, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'h5004, 5'd6);
    flush_in = 1'b1;
    tick(); idle();
    chk("flush_alu_op", {25'd0, alu_op}, 32'd0);
    chk("flush_full", {31'd0, full}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cdb(5'(20 + i), 32'h99);
      tick();
    end
    idle(); tick(); tick(); tick();

    // Stall: rdy_in low holds everything, ignores dispatch and CDB.
    drive_dis(OpSub, 32'hbad, 32'd5, 5'd25, 1'b1, 5'd0, 1'b0, 32'd1, 32'h6000, 5'd12);
    tick();
    drive_dis(OpAnd, 32'hf0, 32'h3c, 5'd0, 1'b0, 5'd0, 1'b0, 32'd2, 32'h6004, 5'd13);
    tick();
    rdy_in = 1'b0;
    drive_dis(OpOr, 32'd1, 32'd1, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'h6008, 5'd14);
    cdb(5'd25, 32'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_alu_op", {25'd0, alu_op}, 32'd0);
      chk("stall_alu_vi", alu_vi, 32'h77);
      chk("stall_alu_rd", {27'd0, alu_rd}, 32'd8);
      chk("stall_full", {31'd0, full}, 32'd0);
    end
    rdy_in = 1'b1;
    idle();
    expect_iss(cyc + 1, OpAnd, 32'hf0, 32'h3c, 32'd2, 32'h6004, 5'd13);
    tick(); tick();
    cdb(5'd25, 32'h66);
    expect_iss(cyc + 2, OpSub, 32'h66, 32'd5, 32'd1, 32'h6000, 5'd12);
    tick(); idle(); tick(); tick();

    // Asynchronous reset mid-operation clears a pending ready entry and the outputs.
    drive_dis(OpAdd, 32'd1, 32'd2, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'h7000, 5'd15);
    expect_iss(cyc + 2, OpAdd, 32'd1, 32'd2, 32'd0, 32'h7000, 5'd15);
    tick();
    drive_dis(OpSub, 32'd3, 32'd4, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'h7004, 5'd16);
    tick(); idle();
    #5 rst_in = 1'b0;
    #1;
    chk("arst_alu_op", {25'd0, alu_op}, 32'd0);
    chk("arst_alu_vi", alu_vi, 32'd0);
    chk("arst_full", {31'd0, full}, 32'd0);
    #2 rst_in = 1'b1;
    tick(); tick(); tick(); tick();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station that feeds the integer ALU: it buffers decoded ALU/branch micro-ops, tracks operand dependencies by ROB tag, snoops the common data bus (CDB) for wake-up, and issues at most one ready micro-op per cycle on the ALU's operand interface. It sits between the decoder/dispatch stage and the combinational ALU, whose result returns to this block via the CDB.

## Interface
Parameters:
- DEPTH, 8, number of entries (power of two, 2..16)
- TAG_W, 5, ROB tag width; also the width of the rd field sent to the ALU

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global ready; when low the block holds all state
- flush_in  in  1  mispredict flush; clears all entries
- dis_valid  in  1  dispatch strobe
- dis_op  in  7  ALU opcode from const.v; 0 = NOP, never dispatched
- dis_vi / dis_vj  in  32  operand values, meaningful when matching q-valid is 0
- dis_qi / dis_qj  in  TAG_W  producer ROB tags
- dis_qi_v / dis_qj_v  in  1  operand still pending
- dis_imm / dis_pc  in  32  immediate and instruction PC
- dis_rob  in  TAG_W  destination ROB tag
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  tag being broadcast
- cdb_value  in  32  broadcast value
- full  out  1  all entries busy
- alu_op  out  7  issued opcode, 0 = idle
- alu_vi / alu_vj / alu_imm / alu_pc  out  32  issued operands
- alu_rd  out  TAG_W  issued ROB tag

## Operation
- Entry fields: busy, op, vi, vj, qi, qj, qi_v, qj_v, imm, pc, rob.
- Dispatch: when dis_valid and !full, write to lowest-index free entry. Dispatch while full is dropped (upstream guarantees it does not happen).
- Dispatch bypass: if cdb_valid and cdb_tag equals dis_qi (dis_qi_v=1), store cdb_value into vi and clear qi_v; same for j.
- Wake-up: every busy entry with q*_v=1 and q* == cdb_tag captures cdb_value and clears q*_v.
- Ready = busy & !qi_v & !qj_v, computed from registered state only.
- Select: lowest-index ready entry; its fields drive the output registers and its busy clears. No ready entry: alu_op <= 0, other outputs hold.
- Dispatch, wake-up and issue may all occur in one cycle on different entries; an entry freed by issue is not reusable until the next cycle.
- full = all busy (registered state).
- Flush: all busy <= 0, alu_op <= 0; outranks dispatch and issue in the same cycle.
- rdy_in low: no state change at all; dis/cdb inputs ignored that cycle.

## Timing
- Reset: all busy = 0, full = 0, alu_op = 0, all other outputs = 0.
- Operands ready at dispatch: entry written at edge N, alu_op valid after edge N+1.
- CDB wake-up at edge N: issue no earlier than after edge N+1.
- Outputs are registered; each alu_op non-zero value lasts exactly one cycle per issued entry.
- Reset asserted mid-operation: immediate clear, no issue afterward until new dispatch.

## Structure
- Opcode encodings and width (7 bits, NOP = 0) stay in const.v; add RS_DEPTH and TAG_W defaults there.
- One sub-module: rs_pick, a parameterized lowest-index priority encoder (DEPTH-bit vector -> index + found), instantiated twice: free-slot select and ready-entry select.

## Test plan
- Reset then dispatch ADD vi=5 vj=7, both ready -> alu_op=ADD, alu_vi=5, alu_vj=7 exactly one cycle after dispatch edge, then alu_op=0.
- Dispatch SUB with qj_v=1, qj=3; 2 cycles later CDB tag 3 value 0x10 -> issue next cycle with alu_vj=0x10; no issue before.
- Dispatch with qi=4 in the same cycle CDB broadcasts tag 4 value 9 -> entry ready, issues next cycle with alu_vi=9.
- Fill 8 ready-blocked entries -> full=1; 9th dispatch dropped; one wake-up + issue -> full=0 the cycle after issue.
- 3 busy entries, flush_in with simultaneous dis_valid -> all busy 0, alu_op=0, dispatched op lost.
- rdy_in low for 3 cycles with ready entry and CDB traffic -> outputs and entries unchanged; issue resumes the cycle rdy_in returns.
